// File: rtl/fetch.sv
// ---------------------------------------------------------------------------
// fetch -- instruction-fetch stage of the 32-bit pipeline.
//
// Owns the program counter, drives the instruction-memory address and
// predicts the next PC with a direct-mapped table of 2-bit saturating
// counters (BHT) plus a tagged branch target buffer (BTB) that share one
// index. The IF/ID register (INSTRUCTION, NEXT_PC, prediction) is what the
// decode stage consumes.
//
// Parameters
//   RESET_PC          PC loaded on reset
//   BHT_BITS          index width; 2^BHT_BITS predictor entries
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   flush             redirect request from branch resolution
//   REDIRECT_PC       correct PC, valid with flush
//   hazard_stall      load-use stall from decode
//   cache_stall       data-cache miss stall
//   IMEM_ADDR         instruction address (= PC, combinational)
//   IMEM_DATA         instruction word for IMEM_ADDR
//   imem_ready        IMEM_DATA valid this cycle
//   is_branch_update  a branch resolved this cycle
//   UPDATE_PC         PC of the resolved branch
//   update_taken      resolved direction
//   UPDATE_TARGET     resolved taken target
//   NEXT_PC           registered PC+4 of the fetched instruction
//   INSTRUCTION       registered instruction word (0 = bubble)
//   prediction        registered taken prediction for INSTRUCTION
// ---------------------------------------------------------------------------
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          BHT_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] REDIRECT_PC,
  input  logic        hazard_stall,
  input  logic        cache_stall,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DATA,
  input  logic        imem_ready,
  input  logic        is_branch_update,
  input  logic [31:0] UPDATE_PC,
  input  logic        update_taken,
  input  logic [31:0] UPDATE_TARGET,
  output logic [31:0] NEXT_PC,
  output logic [31:0] INSTRUCTION,
  output logic        prediction
);

  localparam int ENTRIES = 1 << BHT_BITS;
  localparam int TAG_W   = 30 - BHT_BITS;

  // Predictor storage
  logic [1:0]       bht_reg        [ENTRIES];
  logic             btb_valid_reg  [ENTRIES];
  logic [TAG_W-1:0] btb_tag_reg    [ENTRIES];
  logic [31:0]      btb_target_reg [ENTRIES];

  // Pipeline state
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic [31:0] next_pc_reg;
  logic        pred_reg;

  // Lookup on the current PC
  logic [BHT_BITS-1:0] idx;
  logic [TAG_W-1:0]    tag;
  logic                hit;
  logic                pred_taken;
  logic [31:0]         pc_plus4;
  logic [31:0]         pred_pc;

  assign idx        = pc_reg[BHT_BITS+1:2];
  assign tag        = pc_reg[31:BHT_BITS+2];
  assign hit        = btb_valid_reg[idx] && (btb_tag_reg[idx] == tag);
  assign pred_taken = hit && bht_reg[idx][1];
  assign pc_plus4   = pc_reg + 32'd4;
  assign pred_pc    = pred_taken ? btb_target_reg[idx] : pc_plus4;

  logic stall;
  assign stall = hazard_stall || cache_stall;

  // Training port. Gating on !cache_stall keeps a resolving stage that is
  // frozen by the data cache from applying the same update repeatedly.
  logic                update_en;
  logic [BHT_BITS-1:0] uidx;
  logic [TAG_W-1:0]    utag;
  logic                unused_update_bits;

  assign update_en          = is_branch_update && !cache_stall;
  assign uidx               = UPDATE_PC[BHT_BITS+1:2];
  assign utag               = UPDATE_PC[31:BHT_BITS+2];
  assign unused_update_bits = ^UPDATE_PC[1:0];

  // Program counter: flush beats every stall and an I-cache miss.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= RESET_PC;
    end else if (flush) begin
      pc_reg <= REDIRECT_PC;
    end else if (stall || !imem_ready) begin
      pc_reg <= pc_reg;
    end else begin
      pc_reg <= pred_pc;
    end
  end

  // IF/ID register: a stall holds the slot even while the I-cache misses,
  // so a miss only produces a bubble when decode can accept one.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      instr_reg   <= 32'h0;
      next_pc_reg <= 32'h0;
      pred_reg    <= 1'b0;
    end else if (stall) begin
      instr_reg   <= instr_reg;
      next_pc_reg <= next_pc_reg;
      pred_reg    <= pred_reg;
    end else if (!imem_ready) begin
      instr_reg   <= 32'h0;
      next_pc_reg <= 32'h0;
      pred_reg    <= 1'b0;
    end else begin
      instr_reg   <= IMEM_DATA;
      next_pc_reg <= pc_plus4;
      pred_reg    <= pred_taken;
    end
  end

  // One write port per entry; lookups read the pre-edge value, so a
  // same-cycle update becomes visible on the following cycle.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic sel;
      assign sel = update_en && (uidx == BHT_BITS'(gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          bht_reg[gi]       <= 2'b01;
          btb_valid_reg[gi] <= 1'b0;
        end else if (sel) begin
          if (update_taken) begin
            if (bht_reg[gi] != 2'b11) begin
              bht_reg[gi] <= bht_reg[gi] + 2'b01;
            end
            btb_valid_reg[gi] <= 1'b1;
          end else if (bht_reg[gi] != 2'b00) begin
            bht_reg[gi] <= bht_reg[gi] - 2'b01;
          end
        end
      end

      // Tag/target need no reset: they are only consulted behind valid.
      always_ff @(posedge clk) begin
        if (!reset && sel && update_taken) begin
          btb_tag_reg[gi]    <= utag;
          btb_target_reg[gi] <= UPDATE_TARGET;
        end
      end
    end
  endgenerate

  assign IMEM_ADDR   = pc_reg;
  assign INSTRUCTION = instr_reg;
  assign NEXT_PC     = next_pc_reg;
  assign prediction  = pred_reg;

endmodule

// File: tb/tb_fetch.sv
// ---------------------------------------------------------------------------
// tb_fetch -- scoreboard bench for fetch.
//
// A driver applies inputs on the falling edge and, from a behavioural model
// of the fetch rules, pushes the expected post-edge IMEM_ADDR / IF/ID values
// into a queue. An independent monitor samples the DUT 1 time unit after
// each rising edge and compares against the popped entry.
// ---------------------------------------------------------------------------
module tb_fetch;

  localparam int N = 64;  // 2^BHT_BITS

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;
  logic        hazard_stall = 1'b0;
  logic        cache_stall = 1'b0;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_DATA = 32'h0;
  logic        imem_ready = 1'b0;
  logic        is_branch_update = 1'b0;
  logic [31:0] UPDATE_PC = 32'h0;
  logic        update_taken = 1'b0;
  logic [31:0] UPDATE_TARGET = 32'h0;
  logic [31:0] NEXT_PC;
  logic [31:0] INSTRUCTION;
  logic        prediction;

  fetch #(.RESET_PC(32'h0), .BHT_BITS(6)) dut (
    .clk(clk), .reset(reset), .flush(flush), .REDIRECT_PC(REDIRECT_PC),
    .hazard_stall(hazard_stall), .cache_stall(cache_stall),
    .IMEM_ADDR(IMEM_ADDR), .IMEM_DATA(IMEM_DATA), .imem_ready(imem_ready),
    .is_branch_update(is_branch_update), .UPDATE_PC(UPDATE_PC),
    .update_taken(update_taken), .UPDATE_TARGET(UPDATE_TARGET),
    .NEXT_PC(NEXT_PC), .INSTRUCTION(INSTRUCTION), .prediction(prediction)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        pred;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  // ---- reference model: fetch rules in plain arithmetic ----
  int unsigned m_pc;
  int unsigned m_instr;
  int unsigned m_npc;
  bit          m_pred;
  int          m_cnt [N];
  bit          m_valid [N];
  int unsigned m_tag [N];
  int unsigned m_tgt [N];

  function automatic int unsigned ix(int unsigned a);
    return (a / 4) % N;
  endfunction

  function automatic int unsigned tg(int unsigned a);
    return a / (4 * N);
  endfunction

  task automatic model_step();
    int unsigned i;
    bit          pt;
    int unsigned ppc;
    int unsigned u;
    i   = ix(m_pc);
    pt  = m_valid[i] && (m_tag[i] == tg(m_pc)) && (m_cnt[i] >= 2);
    ppc = pt ? m_tgt[i] : m_pc + 4;
    if (reset) begin
      m_pc = 0; m_instr = 0; m_npc = 0; m_pred = 0;
      for (int k = 0; k < N; k++) begin
        m_cnt[k] = 1;
        m_valid[k] = 0;
      end
    end else begin
      if (flush) begin
        m_instr = 0; m_npc = 0; m_pred = 0;
      end else if (hazard_stall || cache_stall) begin
        // hold
      end else if (!imem_ready) begin
        m_instr = 0; m_npc = 0; m_pred = 0;
      end else begin
        m_instr = IMEM_DATA; m_npc = m_pc + 4; m_pred = pt;
      end
      if (flush) m_pc = REDIRECT_PC;
      else if (!(hazard_stall || cache_stall || !imem_ready)) m_pc = ppc;
      if (is_branch_update && !cache_stall) begin
        u = ix(UPDATE_PC);
        if (update_taken) begin
          if (m_cnt[u] < 3) m_cnt[u]++;
          m_valid[u] = 1;
          m_tag[u]   = tg(UPDATE_PC);
          m_tgt[u]   = UPDATE_TARGET;
        end else if (m_cnt[u] > 0) begin
          m_cnt[u]--;
        end
      end
    end
    exp_q.push_back('{addr: m_pc, instr: m_instr, npc: m_npc, pred: m_pred});
  endtask

  // ---- driver helpers ----
  task automatic idle();
    reset = 0; flush = 0; REDIRECT_PC = 0; hazard_stall = 0; cache_stall = 0;
    imem_ready = 1; IMEM_DATA = $urandom; is_branch_update = 0;
    UPDATE_PC = 0; update_taken = 0; UPDATE_TARGET = 0;
  endtask

  // Inputs have been set since the last falling edge; model the coming edge.
  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] a);
    idle(); flush = 1; REDIRECT_PC = a; step();
  endtask

  task automatic upd(input logic [31:0] a, input bit t, input logic [31:0] tgt);
    idle(); is_branch_update = 1; UPDATE_PC = a; update_taken = t;
    UPDATE_TARGET = tgt; step();
  endtask

  // ---- monitor ----
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        checks++;
        if (IMEM_ADDR !== e.addr || INSTRUCTION !== e.instr ||
            NEXT_PC !== e.npc || prediction !== e.pred) begin
          errors++;
          $display("FAIL txn%0d: got addr=%h instr=%h npc=%h pred=%b, required addr=%h instr=%h npc=%h pred=%b",
                   txn, IMEM_ADDR, INSTRUCTION, NEXT_PC, prediction,
                   e.addr, e.instr, e.npc, e.pred);
        end else begin
          $display("txn%0d ok: addr=%h instr=%h npc=%h pred=%b",
                   txn, IMEM_ADDR, INSTRUCTION, NEXT_PC, prediction);
        end
      end
    end
  end

  // ---- stimulus ----
  initial begin
    @(negedge clk);

    // Reset for two cycles with garbage on the instruction bus
    idle(); reset = 1; IMEM_DATA = 32'hDEADBEEF; step();
    idle(); reset = 1; IMEM_DATA = 32'hDEADBEEF; step();

    // Sequential fetch 0, 4, 8
    idle(); step();
    idle(); step();

    // I-cache miss for 3 cycles at PC=0x8, then the fill
    for (int k = 0; k < 3; k++) begin
      idle(); imem_ready = 0; step();
    end
    idle(); step();

    // Hazard stall then cache stall hold everything
    idle(); hazard_stall = 1; step();
    idle(); cache_stall = 1; step();
    idle(); cache_stall = 1; imem_ready = 0; step();
    idle(); step();

    // Train 0x10 -> 0x40, fetch it, then detrain
    upd(32'h10, 1, 32'h40);
    redirect(32'h10);
    idle(); step();
    idle(); step();
    upd(32'h10, 0, 32'h0);
    upd(32'h10, 0, 32'h0);
    redirect(32'h10);
    idle(); step();
    idle(); step();

    // Flush wins over hazard stall and an I-cache miss
    idle(); flush = 1; REDIRECT_PC = 32'h100; hazard_stall = 1; imem_ready = 0; step();
    idle(); step();

    // Update held for 4 cycles, cache stall in the first 3: one increment
    for (int k = 0; k < 4; k++) begin
      idle(); is_branch_update = 1; UPDATE_PC = 32'h20; update_taken = 1;
      UPDATE_TARGET = 32'h80; cache_stall = (k < 3); step();
    end
    redirect(32'h20);
    idle(); step();
    idle(); step();
    // One not-taken update with a same-cycle flush back to 0x20
    idle(); flush = 1; REDIRECT_PC = 32'h20; is_branch_update = 1;
    UPDATE_PC = 32'h20; update_taken = 0; step();
    idle(); step();

    // Randomized traffic around a small code region, with some aliasing
    for (int k = 0; k < 400; k++) begin
      idle();
      reset        = ($urandom_range(99) == 0);
      flush        = ($urandom_range(7) == 0);
      REDIRECT_PC  = {24'h0, 6'($urandom_range(63)), 2'b00};
      hazard_stall = ($urandom_range(7) == 0);
      cache_stall  = ($urandom_range(7) == 0);
      imem_ready   = ($urandom_range(7) != 0);
      is_branch_update = ($urandom_range(2) == 0);
      UPDATE_PC    = {($urandom_range(3) == 0) ? 24'h1 : 24'h0,
                      6'($urandom_range(63)), 2'b00};
      update_taken = ($urandom_range(3) != 0);
      UPDATE_TARGET = {24'h0, 6'($urandom_range(63)), 2'b00};
      step();
    end

    idle();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the 32-bit pipeline. It owns the program counter and drives the instruction-memory address. It predicts the next PC with a direct-mapped branch history table (BHT) of 2-bit counters plus a tagged branch target buffer (BTB). It registers the IF/ID outputs that the decode stage consumes, and it obeys the decode hazard stall, the data-cache stall and the branch-resolution flush/redirect.

## Interface
- RESET_PC, 32'h0: PC value loaded on reset.
- BHT_BITS, 6: index width; 2^BHT_BITS entries, index = PC[BHT_BITS+1:2]; tag = PC[31:BHT_BITS+2].
- clk  in  1  pipeline clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  mispredict detected downstream; redirect PC.
- REDIRECT_PC  in  32  correct PC, valid when flush=1.
- hazard_stall  in  1  load-use stall from decode.
- cache_stall  in  1  data-cache miss stall.
- IMEM_ADDR  out  32  instruction address; equals PC, combinational.
- IMEM_DATA  in  32  instruction word for IMEM_ADDR.
- imem_ready  in  1  IMEM_DATA valid this cycle (I-cache hit).
- is_branch_update  in  1  a branch resolved this cycle.
- UPDATE_PC  in  32  PC of the resolved branch.
- update_taken  in  1  resolved outcome.
- UPDATE_TARGET  in  32  resolved taken target.
- NEXT_PC  out  32  registered PC+4 of the fetched instruction.
- INSTRUCTION  out  32  registered instruction word; 0 = bubble.
- prediction  out  1  registered taken prediction for INSTRUCTION.

## Operation
- **Lookup** (combinational on PC): idx = PC[BHT_BITS+1:2].
  - hit = BTB_valid[idx] && BTB_tag[idx] == PC tag.
  - pred_taken = hit && BHT[idx][1].
  - PRED_PC = pred_taken ? BTB_target[idx] : PC+4. PC+4 wraps modulo 2^32.
- **PC register update priority:**
  1. reset: PC <= RESET_PC.
  2. flush: PC <= REDIRECT_PC. Flush wins over every stall and over imem_ready=0.
  3. hazard_stall || cache_stall || !imem_ready: PC holds.
  4. Otherwise: PC <= PRED_PC.
- **IF/ID register priority:**
  1. reset or flush: INSTRUCTION, NEXT_PC and prediction all <= 0.
  2. hazard_stall || cache_stall: all three hold.
  3. !imem_ready: bubble; all three <= 0.
  4. Otherwise: INSTRUCTION <= IMEM_DATA, NEXT_PC <= PC+4, prediction <= pred_taken.
- **Predictor update**, applied at the clock edge when is_branch_update && !cache_stall. Gating on !cache_stall prevents a resolving stage that is held by a cache stall from applying the same update more than once. For uidx = UPDATE_PC index:
  - update_taken=1: BHT[uidx] increments, saturating at 2'b11. BTB[uidx] <= {valid=1, tag of UPDATE_PC, UPDATE_TARGET}; the existing entry is overwritten.
  - update_taken=0: BHT[uidx] decrements, saturating at 2'b00. The BTB is unchanged.
- **Reset state:**
  - All BHT counters = 2'b01 (weakly not-taken).
  - All BTB valid bits = 0.
  - PC = RESET_PC.
  - Outputs INSTRUCTION = 0, NEXT_PC = 0, prediction = 0.
  - Reset has priority over flush, stalls and update. A reset asserted mid-stall or mid-update discards that operation.
- The update is not gated by flush, because the flushing branch must train.
- Flush does not touch predictor state except through that update.

## Timing
- IMEM_ADDR follows PC with zero latency. IF/ID outputs appear 1 cycle after the fetch cycle.
- Correctly predicted taken branch: the target is fetched in the cycle immediately after the branch, with no bubble.
- Flush at edge N:
  - IMEM_ADDR = REDIRECT_PC after edge N.
  - INSTRUCTION = 0 after edge N.
  - The redirected instruction appears after edge N+1 if imem_ready=1.
- Same-cycle update and lookup on the same index: the lookup sees the pre-update value. The new value is visible from the next cycle.
- imem_ready low for k cycles: IMEM_ADDR stays constant and k bubbles are issued, unless a stall is holding the IF/ID register.

## Test plan
- **Reset:**
  - Stimulus: assert reset for 2 cycles, IMEM_DATA=32'hDEADBEEF. Then release with imem_ready=1.
  - Response: during reset, INSTRUCTION=0, prediction=0, IMEM_ADDR=0. After release, IMEM_ADDR follows 0, 4, 8 and NEXT_PC follows 4, 8, 12.
- **I-cache miss:**
  - Stimulus: imem_ready=0 for 3 cycles at PC=0x8.
  - Response: IMEM_ADDR stays 0x8 and INSTRUCTION=0 for 3 cycles. Then INSTRUCTION=IMEM_DATA and NEXT_PC=0xC.
- **Stall hold:**
  - Stimulus: hazard_stall=1 for 1 cycle, then cache_stall=1 for 2 cycles.
  - Response: PC, INSTRUCTION, NEXT_PC and prediction are all unchanged across those cycles.
- **Train and predict:**
  - Stimulus: one update with UPDATE_PC=0x10, update_taken=1, UPDATE_TARGET=0x40.
  - Response: the next fetch at PC=0x10 yields prediction=1 and IMEM_ADDR=0x40 on the following cycle.
  - Follow-up: two not-taken updates restore PC+4 prediction.
- **Flush priority:**
  - Stimulus: flush=1 with REDIRECT_PC=0x100, asserted together with hazard_stall=1 and imem_ready=0.
  - Response: PC=0x100 and IF/ID outputs = 0.
- **Update under cache stall:**
  - Stimulus: is_branch_update=1 for PC 0x20 (taken) held for 4 cycles, with cache_stall=1 in the first 3 of them.
  - Response: the counter moves exactly once (01 to 10).
